// File: rtl/quantizer_stream.sv
// Multi-lane IEEE-754 single to uniform level quantizer with valid/ready back-pressure.
// Register chain: input capture, decode, scale, clamp/output; all four advance together.
`timescale 1ns/1ps

module quantizer_stream #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned LEVEL_W = 4,
  parameter int unsigned FRAC_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [LEVEL_W:0]          cfg_levels,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*NUM_CH-1:0]      in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LEVEL_W*NUM_CH-1:0] out_level,
  output logic [NUM_CH-1:0]         out_sat,
  output logic [NUM_CH-1:0]         out_nan
);

  localparam int unsigned LW     = LEVEL_W + 1;
  localparam int unsigned MagW   = FRAC_W + 1;
  localparam int unsigned UW     = FRAC_W + 2;
  localparam int unsigned PW     = FRAC_W + 2 + LEVEL_W + 1;
  localparam int unsigned QW     = PW - (FRAC_W + 1);
  // Right shift that takes 1.mant (23 fraction bits) at exponent e down to FRAC_W bits.
  localparam int unsigned ShBase = 150 - FRAC_W;

  localparam logic [LW-1:0]   LMax   = LW'(1) << LEVEL_W;
  localparam logic [MagW-1:0] MagOne = MagW'(1) << FRAC_W;
  localparam logic [UW-1:0]   UOne   = UW'(1) << FRAC_W;

  logic                             adv;
  logic [LW-1:0]                    l_in;

  logic                             v0_q;
  logic [32*NUM_CH-1:0]             data0_q;
  logic [LW-1:0]                    l0_q;

  logic                             v1_q;
  logic [NUM_CH-1:0][MagW-1:0]      mag1_d, mag1_q;
  logic [NUM_CH-1:0]                neg1_d, neg1_q;
  logic [NUM_CH-1:0]                sat1_d, sat1_q;
  logic [NUM_CH-1:0]                nan1_d, nan1_q;
  logic [LW-1:0]                    l1_q;

  logic                             v2_q;
  logic [NUM_CH-1:0][UW-1:0]        u_d;
  logic [NUM_CH-1:0][PW-1:0]        p2_d, p2_q;
  logic [NUM_CH-1:0]                sat2_q, nan2_q;
  logic [LW-1:0]                    l2_q;

  logic [LW-1:0]                    lmax2;
  logic [NUM_CH-1:0][QW-1:0]        q_d;
  logic [LEVEL_W*NUM_CH-1:0]        level_d;

  assign adv      = en & (~out_valid | out_ready) & ~rst;
  assign in_ready = adv;

  always_comb begin
    l_in = cfg_levels;
    if (cfg_levels < LW'(2)) begin
      l_in = LW'(2);
    end else if (cfg_levels > LMax) begin
      l_in = LMax;
    end
  end

  // Decode: NaN, saturation (|x|>=1 or inf), otherwise truncated fixed-point magnitude.
  always_comb begin
    mag1_d = '0;
    neg1_d = '0;
    sat1_d = '0;
    nan1_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      neg1_d[i] = data0_q[32*i+31];
      if (data0_q[32*i+23 +: 8] == 8'hff && data0_q[32*i +: 23] != '0) begin
        nan1_d[i] = 1'b1;
      end else if (data0_q[32*i+23 +: 8] >= 8'd127) begin
        sat1_d[i] = 1'b1;
        mag1_d[i] = MagOne;
      end else if (data0_q[32*i+23 +: 8] != 8'd0) begin
        mag1_d[i] = MagW'({1'b1, data0_q[32*i +: 23]}
                          >> (9'(ShBase) - {1'b0, data0_q[32*i+23 +: 8]}));
      end
    end
  end

  // Scale: offset to 0..2 and multiply by the level count.
  always_comb begin
    u_d  = '0;
    p2_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      u_d[i]  = neg1_q[i] ? (UOne - UW'(mag1_q[i])) : (UOne + UW'(mag1_q[i]));
      p2_d[i] = PW'(u_d[i]) * PW'(l1_q);
    end
  end

  assign lmax2 = l2_q - LW'(1);

  always_comb begin
    q_d     = '0;
    level_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      q_d[i] = QW'(p2_q[i] >> (FRAC_W + 1));
      if (nan2_q[i]) begin
        level_d[LEVEL_W*i +: LEVEL_W] = '0;
      end else if (q_d[i] > QW'(lmax2)) begin
        level_d[LEVEL_W*i +: LEVEL_W] = LEVEL_W'(lmax2);
      end else begin
        level_d[LEVEL_W*i +: LEVEL_W] = LEVEL_W'(q_d[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q      <= 1'b0;
      data0_q   <= '0;
      l0_q      <= '0;
      v1_q      <= 1'b0;
      mag1_q    <= '0;
      neg1_q    <= '0;
      sat1_q    <= '0;
      nan1_q    <= '0;
      l1_q      <= '0;
      v2_q      <= 1'b0;
      p2_q      <= '0;
      sat2_q    <= '0;
      nan2_q    <= '0;
      l2_q      <= '0;
      out_valid <= 1'b0;
      out_level <= '0;
      out_sat   <= '0;
      out_nan   <= '0;
    end else if (adv) begin
      v0_q      <= in_valid;
      data0_q   <= in_data;
      l0_q      <= l_in;
      v1_q      <= v0_q;
      mag1_q    <= mag1_d;
      neg1_q    <= neg1_d;
      sat1_q    <= sat1_d;
      nan1_q    <= nan1_d;
      l1_q      <= l0_q;
      v2_q      <= v1_q;
      p2_q      <= p2_d;
      sat2_q    <= sat1_q;
      nan2_q    <= nan1_q;
      l2_q      <= l1_q;
      out_valid <= v2_q;
      out_level <= level_d;
      out_sat   <= sat2_q;
      out_nan   <= nan2_q;
    end
  end

endmodule

// File: tb/tb_quantizer_stream.sv
// Directed bench for quantizer_stream: sweep, latency, specials, back-pressure, enable, reset.
`timescale 1ns/1ps

module tb_quantizer_stream;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        en         = 1'b1;
  logic [4:0]  cfg_levels = 5'd10;
  logic        in_valid   = 1'b0;
  logic        in_ready;
  logic [127:0] in_data   = '0;
  logic        out_valid;
  logic        out_ready  = 1'b1;
  logic [15:0] out_level;
  logic [3:0]  out_sat;
  logic [3:0]  out_nan;

  int checks = 0;
  int errors = 0;

  logic [31:0] sweep [10] = '{32'h3F800000, 32'h3F333333, 32'h3F000000, 32'h3E99999A,
                              32'h3DCCCCCD, 32'hBDCCCCCD, 32'hBE99999A, 32'hBF000000,
                              32'hBF333333, 32'hBF800000};
  int lvl10 [10] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int lvl4  [10] = '{3, 3, 3, 2, 2, 1, 1, 1, 0, 0};

  quantizer_stream #(
    .NUM_CH (4),
    .LEVEL_W(4),
    .FRAC_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_levels(cfg_levels),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_level (out_level),
    .out_sat   (out_sat),
    .out_nan   (out_nan)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Lane0 = sweep[idx], lane1 = sweep[9-idx], lane2 = +0, lane3 = -0.
  function automatic logic [127:0] beat_data(input int idx);
    return {32'h80000000, 32'h00000000, sweep[9-idx], sweep[idx]};
  endfunction

  function automatic logic [15:0] exp_level(input int idx, input int l);
    int a;
    int b;
    a = (l == 10) ? lvl10[idx] : lvl4[idx];
    b = (l == 10) ? lvl10[9-idx] : lvl4[9-idx];
    return {4'(l/2), 4'(l/2), 4'(b), 4'(a)};
  endfunction

  function automatic logic [3:0] exp_sat(input int idx);
    return (idx == 0 || idx == 9) ? 4'b0011 : 4'b0000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_level !== 16'h0 || out_sat !== 4'h0 || out_nan !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b lvl=%h sat=%b nan=%b required all zero",
               out_valid, out_level, out_sat, out_nan);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_sweep();
    int q[$];
    int sent = 0;
    int got  = 0;
    int last = -1;
    en = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 10); in_data = beat_data(sent % 10); cfg_levels = 5'd10;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL sweep_spurious: got out_valid=1 required 0");
        end else if (out_level !== exp_level(q[0], 10) || out_sat !== exp_sat(q[0]) ||
                     out_nan !== 4'b0) begin
          errors++;
          $display("FAIL sweep_beat%0d: got lvl=%h sat=%b nan=%b required lvl=%h sat=%b nan=0000",
                   q[0], out_level, out_sat, out_nan, exp_level(q[0], 10), exp_sat(q[0]));
        end
        if (q.size() > 0) begin void'(q.pop_front()); got++; last = cyc; end
      end
      if (in_valid && in_ready) begin q.push_back(sent); sent++; end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 10 || last != 13) begin
      errors++; $display("FAIL sweep_throughput: got %0d beats last@%0d required 10 last@13", got, last);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    cfg_levels = 5'd4; in_valid = 1'b1;
    in_data = {32'h40000000, 32'h00000000, 32'hBE99999A, 32'h3F333333};
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL latency_accept: got in_ready=%b required 1", in_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL latency_early%0d: got out_valid=%b required 0", c, out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_level !== 16'h3213 || out_sat !== 4'b1000 || out_nan !== 4'b0) begin
      errors++;
      $display("FAIL latency_beat: got v=%b lvl=%h sat=%b nan=%b required v=1 lvl=3213 sat=1000 nan=0000",
               out_valid, out_level, out_sat, out_nan);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_specials();
    int cfgs [5] = '{4, 0, 1, 17, 31};
    int half [5] = '{2, 1, 1, 8, 8};
    logic [15:0] want;
    for (int k = 0; k < 5; k++) begin
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; cfg_levels = 5'(cfgs[k]);
      in_data = {32'h00000001, 32'h80000000, 32'hFF800000, 32'h7FC00000};
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && n < 8) begin @(negedge clk); n++; end
      want = {4'(half[k]), 4'(half[k]), 4'h0, 4'h0};
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL specials_timeout%0d: got out_valid=%b required 1", k, out_valid);
      end else if (out_level !== want || out_sat !== 4'b0010 || out_nan !== 4'b0001) begin
        errors++;
        $display("FAIL specials_cfg%0d: got lvl=%h sat=%b nan=%b required lvl=%h sat=0010 nan=0001",
                 cfgs[k], out_level, out_sat, out_nan, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int sent = 0;
    int got  = 0;
    int last = -1;
    en = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      in_valid = (sent < 8); in_data = beat_data(sent % 10); cfg_levels = 5'd10;
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready@%0d: got %b required 0", cyc, in_ready);
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_spurious@%0d: got out_valid=1 required 0", cyc);
        end else if (out_level !== exp_level(q[0], 10) || out_sat !== exp_sat(q[0])) begin
          errors++;
          $display("FAIL bp_beat%0d@%0d: got lvl=%h sat=%b required lvl=%h sat=%b",
                   q[0], cyc, out_level, out_sat, exp_level(q[0], 10), exp_sat(q[0]));
        end
        if (out_ready && q.size() > 0) begin void'(q.pop_front()); got++; last = cyc; end
      end
      if (in_valid && in_ready) begin q.push_back(sent); sent++; end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 8 || q.size() != 0 || last != 16) begin
      errors++;
      $display("FAIL bp_total: got %0d beats left=%0d last@%0d required 8 left=0 last@16",
               got, q.size(), last);
    end
  endtask

  task automatic test_enable();
    int qi[$];
    int ql[$];
    int sent = 0;
    int got  = 0;
    int last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      en = !(cyc >= 6 && cyc < 9);
      in_valid = (sent < 10); in_data = beat_data(sent % 10);
      cfg_levels = (sent < 5) ? 5'd10 : 5'd4;
      #1;
      if (!en) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL en_freeze@%0d: got in_ready=%b out_valid=%b required 0 and 1",
                   cyc, in_ready, out_valid);
        end
      end
      if (out_valid) begin
        checks++;
        if (qi.size() == 0) begin
          errors++; $display("FAIL en_spurious@%0d: got out_valid=1 required 0", cyc);
        end else if (out_level !== exp_level(qi[0], ql[0]) || out_sat !== exp_sat(qi[0])) begin
          errors++;
          $display("FAIL en_beat%0d_L%0d@%0d: got lvl=%h sat=%b required lvl=%h sat=%b", qi[0],
                   ql[0], cyc, out_level, out_sat, exp_level(qi[0], ql[0]), exp_sat(qi[0]));
        end
        if (en && qi.size() > 0) begin
          void'(qi.pop_front()); void'(ql.pop_front()); got++; last = cyc;
        end
      end
      if (in_valid && in_ready) begin
        qi.push_back(sent); ql.push_back((sent < 5) ? 10 : 4); sent++;
      end
    end
    in_valid = 1'b0; en = 1'b1;
    checks++;
    if (got != 10 || last != 16) begin
      errors++; $display("FAIL en_resume: got %0d beats last@%0d required 10 last@16", got, last);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; out_ready = 1'b1; cfg_levels = 5'd10;
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = beat_data(0);
    end
    @(posedge clk);
    #3;
    checks++;
    if (out_valid !== 1'b1 || out_sat !== 4'b0011) begin
      errors++; $display("FAIL arst_pre: got v=%b sat=%b required v=1 sat=0011", out_valid, out_sat);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_level !== 16'h0 || out_sat !== 4'h0 || out_nan !== 4'h0 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_clear: got v=%b lvl=%h sat=%b nan=%b rdy=%b required all zero",
               out_valid, out_level, out_sat, out_nan, in_ready);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = beat_data(3);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL arst_ready: got %b required 1", in_ready);
    end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL arst_early%0d: got out_valid=%b required 0", c, out_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_level !== exp_level(3, 10) || out_sat !== 4'b0) begin
      errors++;
      $display("FAIL arst_beat: got v=%b lvl=%h sat=%b required v=1 lvl=%h sat=0000",
               out_valid, out_level, out_sat, exp_level(3, 10));
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_latency();
    test_specials();
    test_back_to_back();
    test_enable();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
